systolic_matmul_engine: RTL

SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

---
 rtl/systolic_matmul_engine.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic matrix multiplier: A streams right, B streams down,
// each PE keeps one C element. Result is published on a single-cycle done pulse.

module systolic_mac_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16,
   parameter int SATURATE   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  i_load,
   input  logic [BUS_WIDTH-1:0]  i_seed,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_a,
   output logic [DATA_WIDTH-1:0] o_b,
   output logic [BUS_WIDTH-1:0]  o_acc,
   output logic                  o_flag
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic signed [BUS_WIDTH-1:0] P_MAX = {1'b0, {(BUS_WIDTH-1){1'b1}}};
   localparam logic signed [BUS_WIDTH-1:0] P_MIN = {1'b1, {(BUS_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0]        r_a, r_b;
   logic signed [BUS_WIDTH-1:0]  r_acc;
   logic                         r_flag;
   logic signed [PW-1:0]         w_prod;
   logic signed [BUS_WIDTH-1:0]  w_prod_ext;
   logic signed [BUS_WIDTH:0]    w_sum;
   logic                         w_ovf;

   assign w_prod     = PW'($signed(i_a)) * PW'($signed(i_b));
   assign w_prod_ext = BUS_WIDTH'(w_prod);
   // One guard bit: overflow shows up as the two top sum bits disagreeing.
   assign w_sum      = (BUS_WIDTH+1)'(r_acc) + (BUS_WIDTH+1)'(w_prod_ext);
   assign w_ovf      = w_sum[BUS_WIDTH] ^ w_sum[BUS_WIDTH-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_flag <= 1'b0;
      end else if (i_load) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= i_seed;
         r_flag <= 1'b0;
      end else if (i_en) begin
         r_a <= i_a;
         r_b <= i_b;
         if ((SATURATE != 0) && r_flag) begin
            r_acc <= r_acc;
         end else if (w_ovf) begin
            r_flag <= 1'b1;
            if (SATURATE != 0) r_acc <= w_sum[BUS_WIDTH] ? P_MIN : P_MAX;
            else               r_acc <= w_sum[BUS_WIDTH-1:0];
         end else begin
            r_acc <= w_sum[BUS_WIDTH-1:0];
         end
      end
   end

   assign o_a    = r_a;
   assign o_b    = r_b;
   assign o_acc  = r_acc;
   assign o_flag = r_flag;
endmodule

module systolic_matmul_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16,
   parameter int MAX_DIM    = 4,
   parameter int SATURATE   = 0,
   localparam int DIM_W     = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic                                  mode_bit_i,
   input  logic [DIM_W-1:0]                      n_dim_i,
   input  logic [DIM_W-1:0]                      k_dim_i,
   input  logic [DIM_W-1:0]                      m_dim_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_matrix_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_matrix_i,
   input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_i,
   output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_o,
   output logic [MAX_DIM*MAX_DIM-1:0]            flags_o,
   output logic                                  busy_o,
   output logic                                  done_o
);
   localparam int CNT_W = $clog2(3*MAX_DIM + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                                r_state, w_state_nxt;
   logic [CNT_W-1:0]                      r_cnt;
   logic [DIM_W-1:0]                      r_n, r_k, r_m;
   logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] r_a_mat, r_b_mat;
   logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  r_c_out, w_c_nxt;
   logic [MAX_DIM*MAX_DIM-1:0]            r_flags, w_flags_nxt;
   logic                                  r_done;

   logic                                  w_start, w_run, w_last;
   logic [CNT_W-1:0]                      w_last_cnt;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]    w_feed_a, w_feed_b;

   logic [DATA_WIDTH-1:0] w_a_fwd [MAX_DIM][MAX_DIM];
   logic [DATA_WIDTH-1:0] w_b_fwd [MAX_DIM][MAX_DIM];
   logic [BUS_WIDTH-1:0]  w_acc   [MAX_DIM][MAX_DIM];
   logic                  w_flag  [MAX_DIM][MAX_DIM];

   assign w_start    = (r_state == S_IDLE) && start_i;
   assign w_run      = (r_state == S_RUN);
   // Last RUN cycle index is N+K+M-1 = n+k+m+2 with dims stored minus one.
   assign w_last_cnt = CNT_W'(r_n) + CNT_W'(r_k) + CNT_W'(r_m) + CNT_W'(2);
   assign w_last     = (r_cnt == w_last_cnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_n     <= '0;
         r_k     <= '0;
         r_m     <= '0;
         r_a_mat <= '0;
         r_b_mat <= '0;
      end else if (w_start) begin
         r_cnt   <= '0;
         r_n     <= n_dim_i;
         r_k     <= k_dim_i;
         r_m     <= m_dim_i;
         r_a_mat <= a_matrix_i;
         r_b_mat <= b_matrix_i;
      end else if (w_run) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Skewed edge feed: row i carries A[i][t-i], column j carries B[t-j][j].
   always_comb begin
      w_feed_a = '0;
      w_feed_b = '0;
      if (w_run) begin
         for (int i = 0; i < MAX_DIM; i++) begin
            for (int k = 0; k < MAX_DIM; k++) begin
               if (DIM_W'(i) <= r_n && DIM_W'(k) <= r_k && r_cnt == CNT_W'(i + k))
                  w_feed_a[i] = r_a_mat[(i*MAX_DIM + k)*DATA_WIDTH +: DATA_WIDTH];
               if (DIM_W'(i) <= r_m && DIM_W'(k) <= r_k && r_cnt == CNT_W'(i + k))
                  w_feed_b[i] = r_b_mat[(k*MAX_DIM + i)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
         logic [DATA_WIDTH-1:0] w_a_in, w_b_in;
         logic [BUS_WIDTH-1:0]  w_seed;

         if (gj == 0) begin : g_a_edge
            assign w_a_in = w_feed_a[gi];
         end else begin : g_a_int
            assign w_a_in = w_a_fwd[gi][gj-1];
         end
         if (gi == 0) begin : g_b_edge
            assign w_b_in = w_feed_b[gj];
         end else begin : g_b_int
            assign w_b_in = w_b_fwd[gi-1][gj];
         end

         assign w_seed = mode_bit_i ?
            c_matrix_i[(gi*MAX_DIM + gj)*BUS_WIDTH +: BUS_WIDTH] : '0;

         systolic_mac_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUS_WIDTH  (BUS_WIDTH),
            .SATURATE   (SATURATE)
         ) u_pe (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_load (w_start),
            .i_seed (w_seed),
            .i_en   (w_run),
            .i_a    (w_a_in),
            .i_b    (w_b_in),
            .o_a    (w_a_fwd[gi][gj]),
            .o_b    (w_b_fwd[gi][gj]),
            .o_acc  (w_acc[gi][gj]),
            .o_flag (w_flag[gi][gj])
         );
      end
   end

   // Elements outside the active NxM window publish as zero, flag clear.
   always_comb begin
      w_c_nxt     = '0;
      w_flags_nxt = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         for (int j = 0; j < MAX_DIM; j++) begin
            if (DIM_W'(i) <= r_n && DIM_W'(j) <= r_m) begin
               w_c_nxt[(i*MAX_DIM + j)*BUS_WIDTH +: BUS_WIDTH] = w_acc[i][j];
               w_flags_nxt[i*MAX_DIM + j] = w_flag[i][j];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_c_out <= '0;
         r_flags <= '0;
         r_done  <= 1'b0;
      end else if (w_run && w_last) begin
         r_c_out <= w_c_nxt;
         r_flags <= w_flags_nxt;
         r_done  <= 1'b1;
      end else begin
         r_done  <= 1'b0;
      end
   end

   assign c_matrix_o = r_c_out;
   assign flags_o    = r_flags;
   assign busy_o     = (r_state != S_IDLE);
   assign done_o     = r_done;
endmodule
